// File: rtl/ctrl_pkg.sv
// Shared RV32I decode constants, ALU operation codes, control bundle and pipe state type.
package ctrl_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic RstEnable  = 1'b1;
   localparam logic ReadEnable = 1'b1;

   typedef enum logic [4:0] {
      ALU_NOP    = 5'd0,
      ALU_ADD    = 5'd1,
      ALU_SUB    = 5'd2,
      ALU_SLL    = 5'd3,
      ALU_SLT    = 5'd4,
      ALU_SLTU   = 5'd5,
      ALU_XOR    = 5'd6,
      ALU_SRL    = 5'd7,
      ALU_SRA    = 5'd8,
      ALU_OR     = 5'd9,
      ALU_AND    = 5'd10,
      ALU_PASSB  = 5'd11,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_op_e;

   typedef enum logic {
      ST_RUN,
      ST_BUBBLE
   } pipe_state_e;

   typedef struct packed {
      logic       branch;
      logic       jump;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_write;
      logic       reg_read1_e;
      logic       reg_read2_e;
      logic       illegal;
      alu_op_e    alu_op;
      logic [2:0] mem_size;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } ctrl_t;

   // Base-ISA funct3 -> ALU mapping shared by OP and OP-IMM (funct7 qualifiers applied by caller).
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
      case (f3)
         F3_ADD_SUB: return ALU_ADD;
         F3_SLL:     return ALU_SLL;
         F3_SLT:     return ALU_SLT;
         F3_SLTU:    return ALU_SLTU;
         F3_XOR:     return ALU_XOR;
         F3_SRL_SRA: return ALU_SRL;
         F3_OR:      return ALU_OR;
         default:    return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/id_ctrl_pipe_if.sv
// Decode-stage bus: fetch handshake in, ID/EX control slot out. Slave side is the decode stage.
interface id_ctrl_pipe_if #(
   parameter int unsigned ALUOP_W = 5,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned CNT_W   = 16
);
   logic               inst_valid_i;
   logic [31:0]        inst_i;
   logic               inst_ready_o;
   logic               flush_i;
   logic               ex_ready_i;
   logic               out_valid_o;
   logic               branch_o;
   logic               jump_o;
   logic               mem_read_o;
   logic               mem_write_o;
   logic               mem_to_reg_o;
   logic               alu_src_o;
   logic               reg_write_o;
   logic               reg_read1_e_o;
   logic               reg_read2_e_o;
   logic [ALUOP_W-1:0] alu_op_o;
   logic [2:0]         mem_size_o;
   logic [REG_AW-1:0]  rs1_o;
   logic [REG_AW-1:0]  rs2_o;
   logic [REG_AW-1:0]  rd_o;
   logic               illegal_o;
   logic [CNT_W-1:0]   bubble_cnt_o;

   modport master (
      output inst_valid_i, inst_i, flush_i, ex_ready_i,
      input  inst_ready_o, out_valid_o, branch_o, jump_o, mem_read_o, mem_write_o,
             mem_to_reg_o, alu_src_o, reg_write_o, reg_read1_e_o, reg_read2_e_o,
             alu_op_o, mem_size_o, rs1_o, rs2_o, rd_o, illegal_o, bubble_cnt_o
   );

   modport slave (
      input  inst_valid_i, inst_i, flush_i, ex_ready_i,
      output inst_ready_o, out_valid_o, branch_o, jump_o, mem_read_o, mem_write_o,
             mem_to_reg_o, alu_src_o, reg_write_o, reg_read1_e_o, reg_read2_e_o,
             alu_op_o, mem_size_o, rs1_o, rs2_o, rd_o, illegal_o, bubble_cnt_o
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I control decoder. Define RV_MULDIV_EN to decode the M-extension
// (OP, funct7=0000001); otherwise those encodings are reported illegal.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] inst_i,
   output ctrl_t       ctrl_o
);

   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       bad;

   assign opc = inst_i[6:0];
   assign rd  = inst_i[11:7];
   assign f3  = inst_i[14:12];
   assign rs1 = inst_i[19:15];
   assign rs2 = inst_i[24:20];
   assign f7  = inst_i[31:25];

   always_comb begin
      ctrl_o = '0;
      bad    = 1'b0;
      case (opc)
         OPC_OP: begin
            ctrl_o.reg_read1_e = ReadEnable;
            ctrl_o.reg_read2_e = ReadEnable;
            ctrl_o.reg_write   = 1'b1;
            case (f7)
               F7_BASE: ctrl_o.alu_op = alu_from_f3(f3);
               F7_ALT: begin
                  if (f3 == F3_ADD_SUB)      ctrl_o.alu_op = ALU_SUB;
                  else if (f3 == F3_SRL_SRA) ctrl_o.alu_op = ALU_SRA;
                  else                       bad = 1'b1;
               end
`ifdef RV_MULDIV_EN
               F7_MULDIV: ctrl_o.alu_op = alu_op_e'({2'b10, f3});
`endif
               default: bad = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            ctrl_o.reg_read1_e = ReadEnable;
            ctrl_o.alu_src     = 1'b1;
            ctrl_o.reg_write   = 1'b1;
            case (f3)
               F3_SLL: begin
                  if (f7 == F7_BASE) ctrl_o.alu_op = ALU_SLL;
                  else               bad = 1'b1;
               end
               F3_SRL_SRA: begin
                  if (f7 == F7_BASE)     ctrl_o.alu_op = ALU_SRL;
                  else if (f7 == F7_ALT) ctrl_o.alu_op = ALU_SRA;
                  else                   bad = 1'b1;
               end
               default: ctrl_o.alu_op = alu_from_f3(f3);
            endcase
         end
         OPC_LOAD: begin
            if (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
               ctrl_o.reg_read1_e = ReadEnable;
               ctrl_o.mem_read    = 1'b1;
               ctrl_o.mem_to_reg  = 1'b1;
               ctrl_o.alu_src     = 1'b1;
               ctrl_o.reg_write   = 1'b1;
               ctrl_o.alu_op      = ALU_ADD;
               ctrl_o.mem_size    = f3;
            end else begin
               bad = 1'b1;
            end
         end
         OPC_STORE: begin
            if (f3 inside {F3_LB, F3_LH, F3_LW}) begin
               ctrl_o.reg_read1_e = ReadEnable;
               ctrl_o.reg_read2_e = ReadEnable;
               ctrl_o.mem_write   = 1'b1;
               ctrl_o.alu_src     = 1'b1;
               ctrl_o.alu_op      = ALU_ADD;
               ctrl_o.mem_size    = f3;
            end else begin
               bad = 1'b1;
            end
         end
         OPC_BRANCH: begin
            ctrl_o.branch      = 1'b1;
            ctrl_o.reg_read1_e = ReadEnable;
            ctrl_o.reg_read2_e = ReadEnable;
            case (f3)
               F3_BEQ, F3_BNE:   ctrl_o.alu_op = ALU_SUB;
               F3_BLT, F3_BGE:   ctrl_o.alu_op = ALU_SLT;
               F3_BLTU, F3_BGEU: ctrl_o.alu_op = ALU_SLTU;
               default:          bad = 1'b1;
            endcase
         end
         OPC_LUI: begin
            ctrl_o.alu_op    = ALU_PASSB;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_JAL: begin
            ctrl_o.jump      = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.reg_write = 1'b1;
         end
         OPC_JALR: begin
            if (f3 == F3_JALR) begin
               ctrl_o.jump        = 1'b1;
               ctrl_o.reg_read1_e = ReadEnable;
               ctrl_o.alu_src     = 1'b1;
               ctrl_o.alu_op      = ALU_ADD;
               ctrl_o.reg_write   = 1'b1;
            end else begin
               bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase

      // Illegal encodings drop every partially-set control bit.
      if (bad) begin
         ctrl_o         = '0;
         ctrl_o.illegal = 1'b1;
      end else begin
         ctrl_o.rd  = rd;
         ctrl_o.rs1 = ctrl_o.reg_read1_e ? rs1 : '0;
         ctrl_o.rs2 = ctrl_o.reg_read2_e ? rs2 : '0;
         if (rd == '0) ctrl_o.reg_write = 1'b0;
      end
   end

endmodule

// File: rtl/id_ctrl_pipe.sv
// Registered RV32I ID/EX control slot with valid/ready handshake, flush and load-use bubble
// insertion. Honours RV_MULDIV_EN through ctrl_decode.
module id_ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W = 5,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   id_ctrl_pipe_if.slave  bus
);

   ctrl_t       dec;
   pipe_state_e state;
   logic        advance;
   logic        hazard;

   ctrl_decode u_decode (
      .inst_i (bus.inst_i),
      .ctrl_o (dec)
   );

   always_comb begin
      advance = !bus.out_valid_o || bus.ex_ready_i;
      hazard  = (state == ST_RUN) && bus.out_valid_o && bus.mem_read_o &&
                (bus.rd_o != '0) && bus.inst_valid_i &&
                ((dec.reg_read1_e && (REG_AW'(dec.rs1) == bus.rd_o)) ||
                 (dec.reg_read2_e && (REG_AW'(dec.rs2) == bus.rd_o)));
      bus.inst_ready_o = (rst_i != RstEnable) && (bus.flush_i || (advance && !hazard));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i == RstEnable) begin
         state             <= ST_RUN;
         bus.out_valid_o   <= 1'b0;
         bus.branch_o      <= 1'b0;
         bus.jump_o        <= 1'b0;
         bus.mem_read_o    <= 1'b0;
         bus.mem_write_o   <= 1'b0;
         bus.mem_to_reg_o  <= 1'b0;
         bus.alu_src_o     <= 1'b0;
         bus.reg_write_o   <= 1'b0;
         bus.reg_read1_e_o <= 1'b0;
         bus.reg_read2_e_o <= 1'b0;
         bus.alu_op_o      <= '0;
         bus.mem_size_o    <= '0;
         bus.rs1_o         <= '0;
         bus.rs2_o         <= '0;
         bus.rd_o          <= '0;
         bus.illegal_o     <= 1'b0;
         bus.bubble_cnt_o  <= '0;
      end else if (bus.flush_i) begin
         bus.out_valid_o <= 1'b0;
         state           <= ST_RUN;
      end else if (advance) begin
         // A stalled slot (!advance) falls through here and holds every output.
         if (hazard) begin
            bus.out_valid_o <= 1'b0;
            state           <= ST_BUBBLE;
            if (bus.bubble_cnt_o != '1) bus.bubble_cnt_o <= bus.bubble_cnt_o + CNT_W'(1);
         end else if (bus.inst_valid_i) begin
            state             <= ST_RUN;
            bus.out_valid_o   <= 1'b1;
            bus.branch_o      <= dec.branch;
            bus.jump_o        <= dec.jump;
            bus.mem_read_o    <= dec.mem_read;
            bus.mem_write_o   <= dec.mem_write;
            bus.mem_to_reg_o  <= dec.mem_to_reg;
            bus.alu_src_o     <= dec.alu_src;
            bus.reg_write_o   <= dec.reg_write;
            bus.reg_read1_e_o <= dec.reg_read1_e;
            bus.reg_read2_e_o <= dec.reg_read2_e;
            bus.alu_op_o      <= ALUOP_W'(dec.alu_op);
            bus.mem_size_o    <= dec.mem_size;
            bus.rs1_o         <= REG_AW'(dec.rs1);
            bus.rs2_o         <= REG_AW'(dec.rs2);
            bus.rd_o          <= REG_AW'(dec.rd);
            bus.illegal_o     <= dec.illegal;
         end else begin
            state           <= ST_RUN;
            bus.out_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed plus randomized bench for id_ctrl_pipe against a table-driven instruction model.
module tb_id_ctrl_pipe;

   typedef struct {
      bit ill, br, jmp, mr, mw, m2r, asrc, rw, r1e, r2e;
      int alu, msz, rs1, rs2, rd;
   } exp_t;

`ifdef RV_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] inst;
   logic        flush;
   logic        ex_ready;

   int   n_cmp = 0;
   int   n_err = 0;
   bit   m_valid;
   exp_t m_f;
   int   m_cnt;
   bit   last_ready;

   int op_alu [8] = '{1, 3, 4, 5, 6, 7, 9, 10};
   int br_alu [8] = '{2, 2, 0, 0, 4, 4, 5, 5};

   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] LW   = 32'h00012283;
   localparam logic [31:0] ADDR = 32'h00128333;
   localparam logic [31:0] SW   = 32'h00322223;
   localparam logic [31:0] LUI  = 32'h123453B7;
   localparam logic [31:0] BAD  = 32'h0000007F;
   localparam logic [31:0] MUL  = 32'h023100B3;

   always #5 clk = ~clk;

   id_ctrl_pipe_if #(.ALUOP_W(5), .REG_AW(5), .CNT_W(16)) bus ();

   assign bus.inst_valid_i = inst_valid;
   assign bus.inst_i       = inst;
   assign bus.flush_i      = flush;
   assign bus.ex_ready_i   = ex_ready;

   id_ctrl_pipe #(.ALUOP_W(5), .REG_AW(5), .CNT_W(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t e;
      bit   ok;
      int   opc, f3, f7;
      e   = '{default: 0};
      ok  = 1'b1;
      opc = int'(w[6:0]);
      f3  = int'(w[14:12]);
      f7  = int'(w[31:25]);
      case (opc)
         'h33: begin
            e.r1e = 1; e.r2e = 1; e.rw = 1;
            if (f7 == 0) e.alu = op_alu[f3];
            else if (f7 == 'h20 && f3 == 0) e.alu = 2;
            else if (f7 == 'h20 && f3 == 5) e.alu = 8;
            else if (f7 == 1 && MD) e.alu = 16 + f3;
            else ok = 0;
         end
         'h13: begin
            e.r1e = 1; e.asrc = 1; e.rw = 1;
            if (f3 == 1) begin ok = (f7 == 0); e.alu = 3; end
            else if (f3 == 5) begin
               if (f7 == 0) e.alu = 7;
               else if (f7 == 'h20) e.alu = 8;
               else ok = 0;
            end else e.alu = op_alu[f3];
         end
         'h03: begin
            ok = (f3 inside {0, 1, 2, 4, 5});
            e.mr = 1; e.m2r = 1; e.asrc = 1; e.rw = 1; e.r1e = 1; e.alu = 1; e.msz = f3;
         end
         'h23: begin
            ok = (f3 <= 2);
            e.mw = 1; e.r1e = 1; e.r2e = 1; e.asrc = 1; e.alu = 1; e.msz = f3;
         end
         'h63: begin
            e.br = 1; e.r1e = 1; e.r2e = 1; e.alu = br_alu[f3]; ok = (e.alu != 0);
         end
         'h37: begin e.alu = 11; e.asrc = 1; e.rw = 1; end
         'h17: begin e.alu = 1;  e.asrc = 1; e.rw = 1; end
         'h6F: begin e.jmp = 1;  e.alu = 1;  e.rw = 1; end
         'h67: begin
            ok = (f3 == 0); e.jmp = 1; e.r1e = 1; e.asrc = 1; e.alu = 1; e.rw = 1;
         end
         default: ok = 0;
      endcase
      if (!ok) begin
         e     = '{default: 0};
         e.ill = 1;
      end else begin
         e.rd  = int'(w[11:7]);
         e.rs1 = e.r1e ? int'(w[19:15]) : 0;
         e.rs2 = e.r2e ? int'(w[24:20]) : 0;
         if (e.rd == 0) e.rw = 0;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 11))
         0, 1:    begin w[6:0] = 7'h03; if ($urandom_range(0, 1) == 1) w[14:12] = 3'b010; end
         2, 3:    w[6:0] = 7'h33;
         4:       w[6:0] = 7'h13;
         5:       w[6:0] = 7'h23;
         6:       w[6:0] = 7'h63;
         7:       w[6:0] = 7'h37;
         8:       w[6:0] = 7'h17;
         9:       w[6:0] = 7'h6F;
         10:      w[6:0] = 7'h67;
         default: ;
      endcase
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
         0:       w[31:25] = 7'h00;
         1:       w[31:25] = 7'h20;
         2:       w[31:25] = 7'h01;
         default: ;
      endcase
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      exp_t ein;
      bit   adv, haz, rdy;
      @(negedge clk);
      ein = ref_decode(inst);
      adv = !m_valid || ex_ready;
      haz = m_valid && m_f.mr && (m_f.rd != 0) && inst_valid &&
            ((ein.r1e && ein.rs1 == m_f.rd) || (ein.r2e && ein.rs2 == m_f.rd));
      rdy = !rst && (flush || (adv && !haz));
      chk("inst_ready", bus.inst_ready_o, rdy);
      chk("out_valid", bus.out_valid_o, m_valid);
      chk("bubble_cnt", bus.bubble_cnt_o, m_cnt);
      chk("illegal", bus.illegal_o, m_f.ill);
      chk("branch", bus.branch_o, m_f.br);
      chk("jump", bus.jump_o, m_f.jmp);
      chk("mem_read", bus.mem_read_o, m_f.mr);
      chk("mem_write", bus.mem_write_o, m_f.mw);
      chk("mem_to_reg", bus.mem_to_reg_o, m_f.m2r);
      chk("alu_src", bus.alu_src_o, m_f.asrc);
      chk("reg_write", bus.reg_write_o, m_f.rw);
      chk("read1_e", bus.reg_read1_e_o, m_f.r1e);
      chk("read2_e", bus.reg_read2_e_o, m_f.r2e);
      chk("alu_op", bus.alu_op_o, m_f.alu);
      chk("mem_size", bus.mem_size_o, m_f.msz);
      chk("rs1", bus.rs1_o, m_f.rs1);
      chk("rs2", bus.rs2_o, m_f.rs2);
      chk("rd", bus.rd_o, m_f.rd);
      last_ready = rdy;
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_f = '{default: 0}; m_cnt = 0;
      end else if (flush) begin
         m_valid = 0;
      end else if (adv) begin
         if (haz) begin
            m_valid = 0;
            if (m_cnt < 65535) m_cnt++;
         end else if (inst_valid) begin
            m_f = ein; m_valid = 1;
         end else begin
            m_valid = 0;
         end
      end
      #1;
   endtask

   initial begin
      m_valid = 0; m_f = '{default: 0}; m_cnt = 0; last_ready = 0;
      rst = 1; inst_valid = 1; inst = ADDI; ex_ready = 1; flush = 0;
      @(posedge clk); #1;

      step();
      chk("rst_ready_low", bus.inst_ready_o, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      rst = 0;
      step();
      inst_valid = 0; #1;
      chk("addi_valid", bus.out_valid_o, 1);
      chk("addi_alu", bus.alu_op_o, 1);
      chk("addi_src", bus.alu_src_o, 1);
      chk("addi_rw", bus.reg_write_o, 1);
      chk("addi_rd", bus.rd_o, 1);
      chk("addi_r2e", bus.reg_read2_e_o, 0);

      inst_valid = 1; inst = LW;
      step();
      inst = ADDR; #1;
      chk("lu_ready_low", bus.inst_ready_o, 0);
      step();
      chk("lu_bubble_valid", bus.out_valid_o, 0);
      chk("lu_bubble_cnt", bus.bubble_cnt_o, 1);
      chk("lu_ready_back", bus.inst_ready_o, 1);
      step();
      inst_valid = 0; #1;
      chk("lu_add_valid", bus.out_valid_o, 1);
      chk("lu_add_rs1", bus.rs1_o, 5);
      chk("lu_add_rs2", bus.rs2_o, 1);
      step();

      inst_valid = 1; inst = SW;
      step();
      ex_ready = 0; inst = ADDI; #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", bus.out_valid_o, 1);
         chk("stall_mw", bus.mem_write_o, 1);
         chk("stall_rs2", bus.rs2_o, 3);
         chk("stall_ready", bus.inst_ready_o, 0);
         step();
      end
      ex_ready = 1; #1;
      chk("release_ready", bus.inst_ready_o, 1);
      step();
      chk("release_rd", bus.rd_o, 1);

      ex_ready = 0; flush = 1; inst = LUI; #1;
      chk("flush_ready", bus.inst_ready_o, 1);
      step();
      flush = 0; inst_valid = 0; #1;
      chk("flush_valid", bus.out_valid_o, 0);
      chk("flush_drop_rd", bus.rd_o, 1);
      ex_ready = 1;

      inst_valid = 1; inst = BAD;
      step();
      inst_valid = 0; #1;
      chk("bad_illegal", bus.illegal_o, 1);
      chk("bad_valid", bus.out_valid_o, 1);
      chk("bad_alu", bus.alu_op_o, 0);
      chk("bad_rw", bus.reg_write_o, 0);
      inst_valid = 1; inst = MUL;
      step();
      inst_valid = 0; #1;
      chk("mul_illegal", bus.illegal_o, MD ? 0 : 1);
      chk("mul_alu", bus.alu_op_o, MD ? 16 : 0);
      step();

      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 299) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         if (!(inst_valid && !last_ready)) begin
            inst_valid = ($urandom_range(0, 4) != 0);
            inst       = rand_inst();
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
